fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage that drives the IF/ID pipeline register. It owns the PC and issues requests to the instruction memory, which may take several cycles to respond. It hands each fetched instruction and its PC+2 to IF/ID, along with that register's write enable. It also handles stalls from the hazard unit, flushes on taken branches and stops fetching on HLT.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'hE000, encoding injected as a bubble on flush or memory wait
- HLT_OPC, 4'hF, opcode (instr[15:12]) that halts fetch
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- stall  in  1  hazard unit: IF/ID must hold its contents
- branch_taken  in  1  ID/EX resolved taken branch; flush and redirect
- branch_target  in  16  redirect address
- imem_req  out  1  request valid
- imem_addr  out  16  request address; held stable until imem_ready
- imem_rdata  in  16  instruction, valid when imem_ready=1
- imem_ready  in  1  request completes this cycle
- nxt_instr  out  16  instruction to IF/ID
- nxt_PC  out  16  PC+2 of that instruction to IF/ID
- ifid_en  out  1  IF/ID write enable
- halted  out  1  fetch stopped on HLT

## Operation
- Registers:
  - pc (16)
  - drain_addr (16)
  - hold_instr (16)
  - state ∈ {FETCH, HOLD, DRAIN, HALT}
- Reset values:
  - pc=RESET_PC, state=FETCH, hold_instr=NOP_INSTR, drain_addr=0
  - While rst=1: imem_req=0, ifid_en=0, halted=0, nxt_instr=NOP_INSTR, nxt_PC=0
- Arithmetic: pc+2 is 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000 and has no special handling.
- Bubble cycle: nxt_instr=NOP_INSTR, nxt_PC=0, ifid_en=~stall.
- branch_taken has priority over every other condition in every state.
  - The cycle it is asserted is a flush: nxt_instr=NOP_INSTR, nxt_PC=0, ifid_en=1, even if stall=1.
  - pc<=branch_target.
  - hold_instr is discarded.
- FETCH (imem_req=1, imem_addr=pc):
  - branch & imem_ready: next state FETCH.
  - branch & ~imem_ready: drain_addr<=pc, next state DRAIN.
  - ready & ~stall:
    - Outputs: nxt_instr=imem_rdata, nxt_PC=pc+2, ifid_en=1.
    - If imem_rdata[15:12]==HLT_OPC: pc holds, next state HALT.
    - Otherwise pc<=pc+2.
  - ready & stall: ifid_en=0, hold_instr<=imem_rdata, pc holds, next state HOLD.
  - ~ready: bubble cycle, pc holds, state stays FETCH.
- HOLD (imem_req=0; nxt_instr=hold_instr, nxt_PC=pc+2):
  - stall: ifid_en=0, remain in HOLD.
  - ~stall: ifid_en=1; next state HALT if hold_instr is HLT, else pc<=pc+2 and next state FETCH.
- DRAIN (imem_req=1, imem_addr=drain_addr): waits out an abandoned request.
  - Bubble cycle every cycle.
  - imem_rdata is ignored.
  - On imem_ready, next state FETCH (fetches the new pc).
  - A branch during DRAIN updates pc and remains in DRAIN.
- HALT (imem_req=0, halted=1):
  - Bubble cycle every cycle; pc holds.
  - A branch exits to FETCH, because an HLT fetched in a branch shadow is squashed.
  - Otherwise only rst leaves HALT.

## Timing
- nxt_instr, nxt_PC, ifid_en, imem_req and imem_addr are combinational from state, pc, the registers and same-cycle inputs. IF/ID captures them on the next rising edge.
- Zero-wait memory (imem_ready=1 whenever req): one instruction per cycle, and pc advances every cycle.
- N-wait memory: N bubble cycles, then the instruction.
- imem_addr never changes while a request is pending and not yet acknowledged; DRAIN enforces this across redirects.
- Redirect penalty:
  - The flush cycle plus any DRAIN cycles.
  - The target instruction is presented no earlier than the cycle after branch_taken.
- Asserting rst mid-request abandons the request: imem_req drops immediately and state returns to FETCH.

## Test plan
- Reset, zero-wait memory, sequential program at 0x0000: nxt_PC = 0x0002, 0x0004, 0x0006 on consecutive cycles, ifid_en=1 throughout.
- Two-wait memory: two bubble cycles (ifid_en=1, nxt_instr=16'hE000), then the instruction with nxt_PC=pc+2; imem_addr stable throughout.
- stall for 3 cycles while ready returns 16'h1234 at pc 0x0010:
  - ifid_en=0 for 3 cycles and no new imem_req.
  - On release, nxt_instr=16'h1234, nxt_PC=0x0012.
- branch_taken to 0x0100 while a request at 0x0020 is pending:
  - Flush cycle, then DRAIN keeps imem_addr=0x0020 until ready.
  - Next request is at 0x0100.
- HLT (16'hF000) fetched at 0x0030:
  - Delivered once with nxt_PC=0x0032.
  - Then halted=1, imem_req=0, pc=0x0030.
  - A later branch to 0x0040 resumes fetch there.
- rst asserted mid-wait: imem_req=0 asynchronously; after release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a multi-cycle instruction
// memory and feeds the IF/ID register, handling stalls, flushes and HLT.
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'hE000,
   parameter logic [3:0]  HLT_OPC   = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_ready,
   output logic [15:0] nxt_instr,
   output logic [15:0] nxt_PC,
   output logic        ifid_en,
   output logic        halted,
   output logic [1:0]  dbg_state,
   output logic [15:0] dbg_pc
);

   // imem handshake: a request is live while imem_req=1 and completes in the
   // cycle imem_ready=1; imem_addr must not change until that cycle.

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [15:0] pc, pc_n;
   logic [15:0] drain_addr, drain_addr_n;
   logic [15:0] hold_instr, hold_instr_n;
   logic [15:0] pc_plus2;

   logic        req_c;
   logic [15:0] addr_c;
   logic [15:0] instr_c;
   logic [15:0] npc_c;
   logic        en_c;
   logic        halted_c;

   assign pc_plus2 = pc + 16'd2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         drain_addr <= 16'h0000;
         hold_instr <= NOP_INSTR;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         drain_addr <= drain_addr_n;
         hold_instr <= hold_instr_n;
      end
   end

   always_comb begin
      // Default is a bubble with the current registers held.
      state_n      = state;
      pc_n         = pc;
      drain_addr_n = drain_addr;
      hold_instr_n = hold_instr;
      req_c        = 1'b0;
      addr_c       = pc;
      instr_c      = NOP_INSTR;
      npc_c        = 16'h0000;
      en_c         = ~stall;
      halted_c     = 1'b0;

      case (state)
         FETCH: begin
            req_c  = 1'b1;
            addr_c = pc;
            if (branch_taken) begin
               en_c         = 1'b1;
               pc_n         = branch_target;
               hold_instr_n = NOP_INSTR;
               if (!imem_ready) begin
                  drain_addr_n = pc;
                  state_n      = DRAIN;
               end
            end else if (imem_ready && !stall) begin
               instr_c = imem_rdata;
               npc_c   = pc_plus2;
               en_c    = 1'b1;
               if (imem_rdata[15:12] == HLT_OPC) begin
                  state_n = HALT;
               end else begin
                  pc_n = pc_plus2;
               end
            end else if (imem_ready) begin
               en_c         = 1'b0;
               hold_instr_n = imem_rdata;
               state_n      = HOLD;
            end
         end

         HOLD: begin
            instr_c = hold_instr;
            npc_c   = pc_plus2;
            if (branch_taken) begin
               instr_c      = NOP_INSTR;
               npc_c        = 16'h0000;
               en_c         = 1'b1;
               pc_n         = branch_target;
               hold_instr_n = NOP_INSTR;
               state_n      = FETCH;
            end else if (!stall) begin
               en_c = 1'b1;
               if (hold_instr[15:12] == HLT_OPC) begin
                  state_n = HALT;
               end else begin
                  pc_n    = pc_plus2;
                  state_n = FETCH;
               end
            end
         end

         DRAIN: begin
            // Keep presenting the abandoned address until memory acknowledges it.
            req_c  = 1'b1;
            addr_c = drain_addr;
            if (branch_taken) begin
               en_c         = 1'b1;
               pc_n         = branch_target;
               hold_instr_n = NOP_INSTR;
            end
            if (imem_ready) begin
               state_n = FETCH;
            end
         end

         HALT: begin
            halted_c = 1'b1;
            if (branch_taken) begin
               en_c         = 1'b1;
               pc_n         = branch_target;
               hold_instr_n = NOP_INSTR;
               state_n      = FETCH;
            end
         end

         default: begin
            state_n = FETCH;
         end
      endcase
   end

   // Reset must silence the outputs immediately, not at the next edge.
   assign imem_req  = ~rst & req_c;
   assign imem_addr = addr_c;
   assign nxt_instr = rst ? NOP_INSTR : instr_c;
   assign nxt_PC    = rst ? 16'h0000 : npc_c;
   assign ifid_en   = ~rst & en_c;
   assign halted    = ~rst & halted_c;
   assign dbg_state = state;
   assign dbg_pc    = pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID writes.
module tb_fetch_stage;

   localparam logic [15:0] NOP = 16'hE000;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic [15:0] nxt_instr;
   logic [15:0] nxt_PC;
   logic        ifid_en;
   logic        halted;
   logic [1:0]  dbg_state;
   logic [15:0] dbg_pc;

   int errors = 0;
   int checks = 0;
   logic [32:0] exp_q[$];

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .nxt_instr     (nxt_instr),
      .nxt_PC        (nxt_PC),
      .ifid_en       (ifid_en),
      .halted        (halted),
      .dbg_state     (dbg_state),
      .dbg_pc        (dbg_pc)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Program image: a few fixed words, otherwise opcode 2 tagged with the address.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0010) return 16'h1234;
      if (a == 16'h0030) return 16'hF000;
      return {4'h2, a[11:0]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, push the expected IF/ID write, then compare.
   task automatic cyc(input logic s, input logic b, input logic [15:0] t, input logic r,
                      input logic chk_data, input logic e_en, input logic [15:0] e_instr,
                      input logic [15:0] e_pc, input logic e_req, input logic [15:0] e_addr,
                      input logic e_halt);
      logic [32:0] e;
      @(negedge clk);
      stall         = s;
      branch_taken  = b;
      branch_target = t;
      imem_ready    = r;
      exp_q.push_back({e_en, e_instr, e_pc});
      #2;
      e = exp_q.pop_front();
      if (chk_data) check("ifid_out", {ifid_en, nxt_instr, nxt_PC}, e);
      else check("ifid_en", 33'(ifid_en), 33'(e[32]));
      check("imem_req", 33'(imem_req), 33'(e_req));
      if (e_req) check("imem_addr", 33'(imem_addr), 33'(e_addr));
      check("halted", 33'(halted), 33'(e_halt));
   endtask

   initial begin
      rst           = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 16'h0000;
      imem_ready    = 1'b0;

      // Reset state
      @(negedge clk);
      #2;
      check("rst_req", 33'(imem_req), 33'(1'b0));
      check("rst_out", {ifid_en, nxt_instr, nxt_PC}, {1'b0, NOP, 16'h0000});
      check("rst_halted", 33'(halted), 33'(1'b0));
      check("rst_pc", 33'(dbg_pc), 33'(16'h0000));
      rst = 1'b0;

      // Zero-wait sequential fetch
      cyc(0, 0, 16'h0, 1, 1, 1, 16'h2000, 16'h0002, 1, 16'h0000, 0);
      cyc(0, 0, 16'h0, 1, 1, 1, 16'h2002, 16'h0004, 1, 16'h0002, 0);
      cyc(0, 0, 16'h0, 1, 1, 1, 16'h2004, 16'h0006, 1, 16'h0004, 0);

      // Two-wait memory at 0x0006
      cyc(0, 0, 16'h0, 0, 1, 1, NOP, 16'h0000, 1, 16'h0006, 0);
      cyc(0, 0, 16'h0, 0, 1, 1, NOP, 16'h0000, 1, 16'h0006, 0);
      cyc(0, 0, 16'h0, 1, 1, 1, 16'h2006, 16'h0008, 1, 16'h0006, 0);

      for (int a = 8; a < 16; a += 2)
         cyc(0, 0, 16'h0, 1, 1, 1, 16'h2000 | 16'(a), 16'(a + 2), 1, 16'(a), 0);

      // Stall for 3 cycles with the word at 0x0010 returned on the first
      cyc(1, 0, 16'h0, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0010, 0);
      cyc(1, 0, 16'h0, 0, 1, 0, 16'h1234, 16'h0012, 0, 16'h0000, 0);
      cyc(1, 0, 16'h0, 0, 1, 0, 16'h1234, 16'h0012, 0, 16'h0000, 0);
      cyc(0, 0, 16'h0, 0, 1, 1, 16'h1234, 16'h0012, 0, 16'h0000, 0);

      for (int a = 16'h12; a < 16'h20; a += 2)
         cyc(0, 0, 16'h0, 1, 1, 1, 16'h2000 | 16'(a), 16'(a + 2), 1, 16'(a), 0);

      // Branch to 0x0100 while 0x0020 is pending
      cyc(0, 0, 16'h0,    0, 1, 1, NOP, 16'h0000, 1, 16'h0020, 0);
      cyc(0, 1, 16'h0100, 0, 1, 1, NOP, 16'h0000, 1, 16'h0020, 0);
      cyc(0, 0, 16'h0,    0, 1, 1, NOP, 16'h0000, 1, 16'h0020, 0);
      check("drain_state", 33'(dbg_state), 33'(2'd2));
      cyc(0, 0, 16'h0,    1, 1, 1, NOP, 16'h0000, 1, 16'h0020, 0);
      cyc(0, 0, 16'h0,    1, 1, 1, 16'h2100, 16'h0102, 1, 16'h0100, 0);

      // Flush under stall redirects to 0x0030, where HLT lives
      cyc(1, 1, 16'h0030, 1, 1, 1, NOP, 16'h0000, 1, 16'h0102, 0);
      cyc(0, 0, 16'h0,    1, 1, 1, 16'hF000, 16'h0032, 1, 16'h0030, 0);
      cyc(0, 0, 16'h0,    0, 1, 1, NOP, 16'h0000, 0, 16'h0000, 1);
      check("halt_pc", 33'(dbg_pc), 33'(16'h0030));
      cyc(1, 0, 16'h0,    1, 1, 0, NOP, 16'h0000, 0, 16'h0000, 1);
      cyc(0, 1, 16'h0040, 0, 1, 1, NOP, 16'h0000, 0, 16'h0000, 1);
      cyc(0, 0, 16'h0,    1, 1, 1, 16'h2040, 16'h0042, 1, 16'h0040, 0);

      // PC wrap at 0xFFFE
      cyc(0, 1, 16'hFFFE, 1, 1, 1, NOP, 16'h0000, 1, 16'h0042, 0);
      cyc(0, 0, 16'h0,    1, 1, 1, 16'h2FFE, 16'h0000, 1, 16'hFFFE, 0);
      cyc(0, 0, 16'h0,    1, 1, 1, 16'h2000, 16'h0002, 1, 16'h0000, 0);

      // Reset in the middle of a wait at 0x0002
      cyc(0, 0, 16'h0,    0, 1, 1, NOP, 16'h0000, 1, 16'h0002, 0);
      rst = 1'b1;
      #1;
      check("midrst_req", 33'(imem_req), 33'(1'b0));
      check("midrst_out", {ifid_en, nxt_instr, nxt_PC}, {1'b0, NOP, 16'h0000});
      check("midrst_state", 33'(dbg_state), 33'(2'd0));
      check("midrst_pc", 33'(dbg_pc), 33'(16'h0000));
      @(negedge clk);
      rst = 1'b0;
      cyc(0, 0, 16'h0,    1, 1, 1, 16'h2000, 16'h0002, 1, 16'h0000, 0);

      check("scoreboard_empty", 33'(exp_q.size()), 33'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
